game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_pkg.sv | 37 +++
 rtl/game_sequencer_turn_timer.sv | 26 ++
 rtl/game_sequencer.sv | 164 ++++++++++++++++
 tb/tb_game_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the game sequencer: action codes, FSM phases and winner codes.
package game_pkg;

    typedef enum logic [2:0] {
        ACT_KICK  = 3'd0,
        ACT_PUNCH = 3'd1,
        ACT_SABR  = 3'd2,
        ACT_JUMP  = 3'd3,
        ACT_LEFT  = 3'd4,
        ACT_RIGHT = 3'd5
    } action_e;

    localparam logic [2:0] IDLE_ACT = 3'b110;

    localparam logic [2:0] PH_IDLE       = 3'd0;
    localparam logic [2:0] PH_ROUND_INIT = 3'd1;
    localparam logic [2:0] PH_COLLECT    = 3'd2;
    localparam logic [2:0] PH_STEP       = 3'd3;
    localparam logic [2:0] PH_RESOLVE    = 3'd4;
    localparam logic [2:0] PH_GAME_OVER  = 3'd5;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    function automatic logic act_is_legal(input logic [2:0] code);
        return code <= ACT_RIGHT;
    endfunction

    function automatic logic [1:0] lives_dec(input logic [1:0] lives);
        return (lives == 2'd0) ? 2'd0 : lives - 2'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_turn_timer.sv
// turn_timer: loadable down-counter that measures one action-collection turn.
module turn_timer #(
    parameter logic [15:0] TURN_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else if (load_i) begin
            count_q <= TURN_CYCLES - 16'd1;
        end else if (dec_i && count_q != 16'd0) begin
            count_q <= count_q - 16'd1;
        end
    end

    assign zero_o = (count_q == 16'd0);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: turn-based two-player controller (collect actions, step, resolve lives).
// Optional macro GAME_SEQ_EARLY_STEP_EN ends a turn once both players have latched an action.
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [15:0] TURN_CYCLES = 16'd1000,
    parameter logic [1:0]  LIVES_INIT  = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       act1_valid,
    input  logic       act2_valid,
    input  logic [2:0] act1,
    input  logic [2:0] act2,
    input  logic [3:0] pstate1,
    input  logic [3:0] pstate2,
    output logic       step,
    output logic [2:0] action1_out,
    output logic [2:0] action2_out,
    output logic       round_reset_n,
    output logic [1:0] lives1,
    output logic [1:0] lives2,
    output logic [1:0] winner,
    output logic       game_over,
    output logic [2:0] phase
);

    logic [2:0] state_q,  state_d;
    logic [1:0] lives1_q, lives1_d;
    logic [1:0] lives2_q, lives2_d;
    logic [1:0] winner_q, winner_d;
    logic [2:0] act1_q,   act1_d;
    logic [2:0] act2_q,   act2_d;
    logic       got1_q,   got1_d;
    logic       got2_q,   got2_d;
    logic       timer_load, timer_dec, timer_zero;
    logic       take1, take2;
    logic       unused_place;

    assign unused_place = ^{pstate1[3:2], pstate2[3:2]};

    turn_timer #(.TURN_CYCLES(TURN_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (timer_load),
        .dec_i  (timer_dec),
        .zero_o (timer_zero)
    );

    assign take1 = act1_valid && act_is_legal(act1) && !got1_q;
    assign take2 = act2_valid && act_is_legal(act2) && !got2_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d    = state_q;
        lives1_d   = lives1_q;
        lives2_d   = lives2_q;
        winner_d   = winner_q;
        act1_d     = act1_q;
        act2_d     = act2_q;
        got1_d     = got1_q;
        got2_d     = got2_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        case (state_q)
            PH_IDLE, PH_GAME_OVER: begin
                if (start) begin
                    state_d  = PH_ROUND_INIT;
                    lives1_d = LIVES_INIT;
                    lives2_d = LIVES_INIT;
                    winner_d = WIN_NONE;
                end
            end
            PH_ROUND_INIT: begin
                state_d    = PH_COLLECT;
                timer_load = 1'b1;
                act1_d     = IDLE_ACT;
                act2_d     = IDLE_ACT;
                got1_d     = 1'b0;
                got2_d     = 1'b0;
            end
            PH_COLLECT: begin
                timer_dec = 1'b1;
                if (take1) begin
                    act1_d = act1;
                    got1_d = 1'b1;
                end
                if (take2) begin
                    act2_d = act2;
                    got2_d = 1'b1;
                end
                if (timer_zero) begin
                    state_d = PH_STEP;
                end
`ifdef GAME_SEQ_EARLY_STEP_EN
                else if (got1_d && got2_d) begin
                    state_d = PH_STEP;
                end
`else
`endif
            end
            PH_STEP: begin
                state_d = PH_RESOLVE;
            end
            PH_RESOLVE: begin
                if (pstate1[1:0] == 2'd0) lives1_d = lives_dec(lives1_q);
                if (pstate2[1:0] == 2'd0) lives2_d = lives_dec(lives2_q);
                if (lives1_d == 2'd0 || lives2_d == 2'd0) begin
                    state_d  = PH_GAME_OVER;
                    // Bit 1 flags a P1 loss, bit 0 a P2 loss; both set is a draw.
                    winner_d = {lives1_d == 2'd0, lives2_d == 2'd0};
                end else if (pstate1[1:0] == 2'd0 || pstate2[1:0] == 2'd0) begin
                    state_d = PH_ROUND_INIT;
                end else begin
                    state_d    = PH_COLLECT;
                    timer_load = 1'b1;
                    act1_d     = IDLE_ACT;
                    act2_d     = IDLE_ACT;
                    got1_d     = 1'b0;
                    got2_d     = 1'b0;
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PH_IDLE;
            lives1_q <= LIVES_INIT;
            lives2_q <= LIVES_INIT;
            winner_q <= WIN_NONE;
            act1_q   <= IDLE_ACT;
            act2_q   <= IDLE_ACT;
            got1_q   <= 1'b0;
            got2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives1_q <= lives1_d;
            lives2_q <= lives2_d;
            winner_q <= winner_d;
            act1_q   <= act1_d;
            act2_q   <= act2_d;
            got1_q   <= got1_d;
            got2_q   <= got2_d;
        end
    end

    assign step          = (state_q == PH_STEP);
    assign round_reset_n = !(state_q == PH_IDLE || state_q == PH_ROUND_INIT);
    assign game_over     = (state_q == PH_GAME_OVER);
    assign action1_out   = act1_q;
    assign action2_out   = act2_q;
    assign lives1        = lives1_q;
    assign lives2        = lives2_q;
    assign winner        = winner_q;
    assign phase         = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: scripted and random turns against a game-level model.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int          TCI = 4;
    localparam logic [15:0] TC  = 16'(TCI);
    localparam logic [1:0]  LI  = 2'd3;

    logic       clk = 1'b0;
    logic       reset, start, act1_valid, act2_valid;
    logic [2:0] act1, act2;
    logic [3:0] pstate1, pstate2;
    logic       step, round_reset_n, game_over;
    logic [2:0] action1_out, action2_out, phase;
    logic [1:0] lives1, lives2, winner;

    always #5 clk = ~clk;

    game_sequencer #(.TURN_CYCLES(TC), .LIVES_INIT(LI)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .act1_valid    (act1_valid),
        .act2_valid    (act2_valid),
        .act1          (act1),
        .act2          (act2),
        .pstate1       (pstate1),
        .pstate2       (pstate2),
        .step          (step),
        .action1_out   (action1_out),
        .action2_out   (action2_out),
        .round_reset_n (round_reset_n),
        .lives1        (lives1),
        .lives2        (lives2),
        .winner        (winner),
        .game_over     (game_over),
        .phase         (phase)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_lives1, m_lives2;
    logic [1:0] m_winner;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] alive_ps();
        return {2'($urandom_range(3, 0)), 2'($urandom_range(3, 1))};
    endfunction

    task automatic test_reset();
        n_checks++; if (phase !== PH_IDLE) begin n_fail++; $display("FAIL reset_phase: got %0d want %0d", phase, PH_IDLE); end
        n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step); end
        n_checks++; if (round_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_rrn: got %b want 0", round_reset_n); end
        n_checks++; if (action1_out !== 3'b110 || action2_out !== 3'b110) begin n_fail++; $display("FAIL reset_actions: got %0d/%0d want 6/6", action1_out, action2_out); end
        n_checks++; if (lives1 !== LI || lives2 !== LI) begin n_fail++; $display("FAIL reset_lives: got %0d/%0d want %0d", lives1, lives2, LI); end
        n_checks++; if (winner !== 2'b00 || game_over !== 1'b0) begin n_fail++; $display("FAIL reset_winner: got %b/%b want 00/0", winner, game_over); end
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (phase !== PH_IDLE || round_reset_n !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got phase %0d rrn %b want %0d 0", phase, round_reset_n, PH_IDLE); end
    endtask

    task automatic start_game(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_lives1 = int'(LI);
        m_lives2 = int'(LI);
        n_checks++; if (phase !== PH_ROUND_INIT || round_reset_n !== 1'b0) begin n_fail++; $display("FAIL %s start_init: got phase %0d rrn %b want %0d 0", tag, phase, round_reset_n, PH_ROUND_INIT); end
        n_checks++; if (lives1 !== LI || lives2 !== LI || winner !== 2'b00 || game_over !== 1'b0) begin n_fail++; $display("FAIL %s start_regs: got lives %0d/%0d win %b go %b", tag, lives1, lives2, winner, game_over); end
        tick();
        n_checks++; if (phase !== PH_COLLECT || round_reset_n !== 1'b1) begin n_fail++; $display("FAIL %s start_collect: got phase %0d rrn %b want %0d 1", tag, phase, round_reset_n, PH_COLLECT); end
    endtask

    // Modes: 0 random, 1 silent, 2 p1 double strobe, 3 both in cycle 1, 4 strobes on last cycle.
    task automatic run_turn(input int mode, input logic [1:0] h1, input logic [1:0] h2, input string tag);
        logic       v1 [1:TCI+2];
        logic       v2 [1:TCI+2];
        logic [2:0] c1 [1:TCI+2];
        logic [2:0] c2 [1:TCI+2];
        logic [2:0] e1, e2;
        bit         g1, g2;
        int         exp_len, seen;
        for (int k = 1; k <= TCI + 2; k++) begin
            v1[k] = 1'b0; v2[k] = 1'b0; c1[k] = 3'd0; c2[k] = 3'd0;
        end
        case (mode)
            0: for (int k = 1; k <= TCI; k++) begin
                v1[k] = ($urandom_range(2, 0) == 0); c1[k] = 3'($urandom_range(7, 0));
                v2[k] = ($urandom_range(2, 0) == 0); c2[k] = 3'($urandom_range(7, 0));
            end
            2: begin v1[1] = 1'b1; c1[1] = 3'd5; v1[2] = 1'b1; c1[2] = 3'd4; end
            3: begin v1[1] = 1'b1; c1[1] = 3'd1; v2[1] = 1'b1; c2[1] = 3'd2; end
            4: begin
                v1[1] = 1'b1; c1[1] = 3'd7; v2[2] = 1'b1; c2[2] = 3'd6;
                v1[TCI] = 1'b1; c1[TCI] = 3'd3; v2[TCI] = 1'b1; c2[TCI] = 3'd0;
            end
            default: ;
        endcase
        e1 = 3'b110; e2 = 3'b110; g1 = 0; g2 = 0; exp_len = TCI;
        for (int k = 1; k <= TCI; k++) begin
            if (!g1 && v1[k] && c1[k] <= 3'd5) begin e1 = c1[k]; g1 = 1; end
            if (!g2 && v2[k] && c2[k] <= 3'd5) begin e2 = c2[k]; g2 = 1; end
`ifdef GAME_SEQ_EARLY_STEP_EN
            if (g1 && g2) begin exp_len = k; break; end
`endif
        end
        seen = 0;
        for (int k = 1; k <= TCI + 2; k++) begin
            act1_valid = v1[k]; act1 = c1[k];
            act2_valid = v2[k]; act2 = c2[k];
            start = (mode == 0) ? ($urandom_range(1, 0) == 1) : 1'b0;
            tick();
            if (phase === PH_STEP) begin seen = k; break; end
            n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL %s early_step: got %b want 0 at cycle %0d", tag, step, k); end
        end
        act1_valid = 1'b0; act2_valid = 1'b0; start = 1'b0;
        n_checks++; if (seen != exp_len) begin n_fail++; $display("FAIL %s step_cycle: got %0d want %0d", tag, seen, exp_len); end
        n_checks++; if (step !== 1'b1 || round_reset_n !== 1'b1) begin n_fail++; $display("FAIL %s step_pulse: got step %b rrn %b want 1 1", tag, step, round_reset_n); end
        n_checks++; if (action1_out !== e1 || action2_out !== e2) begin n_fail++; $display("FAIL %s step_actions: got %0d/%0d want %0d/%0d", tag, action1_out, action2_out, e1, e2); end
        pstate1 = {2'($urandom_range(3, 0)), h1};
        pstate2 = {2'($urandom_range(3, 0)), h2};
        tick();
        n_checks++; if (phase !== PH_RESOLVE || step !== 1'b0) begin n_fail++; $display("FAIL %s resolve: got phase %0d step %b want %0d 0", tag, phase, step, PH_RESOLVE); end
        n_checks++; if (action1_out !== e1 || action2_out !== e2) begin n_fail++; $display("FAIL %s resolve_actions: got %0d/%0d want %0d/%0d", tag, action1_out, action2_out, e1, e2); end
        if (h1 == 2'd0 && m_lives1 > 0) m_lives1--;
        if (h2 == 2'd0 && m_lives2 > 0) m_lives2--;
        tick();
        pstate1 = alive_ps();
        pstate2 = alive_ps();
        n_checks++; if (lives1 !== 2'(m_lives1) || lives2 !== 2'(m_lives2)) begin n_fail++; $display("FAIL %s lives: got %0d/%0d want %0d/%0d", tag, lives1, lives2, m_lives1, m_lives2); end
        if (m_lives1 == 0 || m_lives2 == 0) begin
            if (m_lives1 == 0 && m_lives2 == 0) m_winner = 2'b11;
            else if (m_lives2 == 0)            m_winner = 2'b01;
            else                               m_winner = 2'b10;
            n_checks++; if (phase !== PH_GAME_OVER || game_over !== 1'b1) begin n_fail++; $display("FAIL %s game_over: got phase %0d go %b want %0d 1", tag, phase, game_over, PH_GAME_OVER); end
            n_checks++; if (winner !== m_winner) begin n_fail++; $display("FAIL %s winner: got %b want %b", tag, winner, m_winner); end
        end else if (h1 == 2'd0 || h2 == 2'd0) begin
            n_checks++; if (phase !== PH_ROUND_INIT || round_reset_n !== 1'b0) begin n_fail++; $display("FAIL %s round_init: got phase %0d rrn %b want %0d 0", tag, phase, round_reset_n, PH_ROUND_INIT); end
            tick();
            n_checks++; if (phase !== PH_COLLECT || round_reset_n !== 1'b1) begin n_fail++; $display("FAIL %s recollect: got phase %0d rrn %b want %0d 1", tag, phase, round_reset_n, PH_COLLECT); end
        end else begin
            n_checks++; if (phase !== PH_COLLECT || round_reset_n !== 1'b1 || winner !== 2'b00) begin n_fail++; $display("FAIL %s next_turn: got phase %0d rrn %b win %b", tag, phase, round_reset_n, winner); end
        end
    endtask

    task automatic test_game_over_hold(input string tag);
        for (int t = 0; t < 3; t++) begin
            act1_valid = 1'b1; act1 = 3'($urandom_range(5, 0));
            act2_valid = 1'b1; act2 = 3'($urandom_range(5, 0));
            pstate1 = {2'b00, 2'($urandom_range(3, 0))};
            pstate2 = {2'b00, 2'($urandom_range(3, 0))};
            tick();
            n_checks++;
            if (phase !== PH_GAME_OVER || game_over !== 1'b1 || winner !== m_winner || step !== 1'b0 ||
                lives1 !== 2'(m_lives1) || lives2 !== 2'(m_lives2)) begin
                n_fail++;
                $display("FAIL %s hold: got phase %0d go %b win %b step %b lives %0d/%0d want win %b lives %0d/%0d",
                         tag, phase, game_over, winner, step, lives1, lives2, m_winner, m_lives1, m_lives2);
            end
        end
        act1_valid = 1'b0; act2_valid = 1'b0;
        pstate1 = alive_ps(); pstate2 = alive_ps();
        start_game({tag, "_restart"});
    endtask

    task automatic test_p1_wins();
        for (int t = 0; t < int'(LI); t++) run_turn(0, 2'd3, 2'd0, "p1_wins");
        test_game_over_hold("p1_wins");
    endtask

    task automatic test_draw();
        for (int t = 0; t < int'(LI); t++) run_turn(1, 2'd0, 2'd0, "draw");
        test_game_over_hold("draw");
    endtask

    task automatic test_random_games();
        logic [1:0] h1, h2;
        for (int t = 0; t < 40; t++) begin
            h1 = ($urandom_range(3, 0) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
            h2 = ($urandom_range(3, 0) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
            run_turn(0, h1, h2, "random");
            if (m_lives1 == 0 || m_lives2 == 0) test_game_over_hold("random");
        end
    endtask

    task automatic test_mid_reset();
        tick();
        tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        n_checks++; if (phase !== PH_IDLE || step !== 1'b0 || round_reset_n !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got phase %0d step %b rrn %b want %0d 0 0", phase, step, round_reset_n, PH_IDLE); end
        n_checks++; if (lives1 !== LI || lives2 !== LI || winner !== 2'b00 || action1_out !== 3'b110 || action2_out !== 3'b110) begin n_fail++; $display("FAIL mid_reset_regs: got lives %0d/%0d win %b acts %0d/%0d", lives1, lives2, winner, action1_out, action2_out); end
        reset = 1'b0;
        start = 1'b0;
        tick();
        n_checks++; if (phase !== PH_IDLE) begin n_fail++; $display("FAIL post_reset_idle: got %0d want %0d", phase, PH_IDLE); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        act1_valid = 1'b0; act2_valid = 1'b0; act1 = 3'd0; act2 = 3'd0;
        pstate1 = alive_ps(); pstate2 = alive_ps();
        m_lives1 = int'(LI); m_lives2 = int'(LI); m_winner = 2'b00;
        tick();
        tick();
        test_reset();
        start_game("first");
        run_turn(1, 2'd3, 2'd3, "no_strobe");
        run_turn(2, 2'd3, 2'd2, "first_wins");
        run_turn(4, 2'd2, 2'd1, "zero_cycle");
        run_turn(3, 2'd1, 2'd1, "both_cycle1");
        test_p1_wins();
        test_draw();
        test_random_games();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
